// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller: the CPU writes a source page to FF46 and the block
// then walks 160 bytes from {page, 00} to {page, 9F} into OAM, one byte
// per machine cycle. Echo RAM pages (E0-FF) fold back onto C000-DFFF.
module oam_dma_ctrl (
  input  logic        clk,
  input  logic        nreset,
  input  logic        mcyc_en,
  input  logic [15:0] a,
  input  logic [7:0]  d,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  output logic [7:0]  q,
  output logic        q_oe,
  output logic        dma_run,
  output logic [15:0] dma_a,
  output logic        oam_addr_ndma,
  output logic        vram_to_oam,
  output logic        dma_oam_wr
);

  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [7:0]  LAST_IDX     = 8'h9F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    RUN   = 2'd2
  } dma_state_e;

  dma_state_e state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] src_hi_q, src_hi_d;
  logic [7:0] active_hi_q, active_hi_d;
  logic       restart_pend_q, restart_pend_d;
  logic       reg_wr;

  // Pages at or above E0 are echo RAM and alias the C000-DFFF work RAM.
  function automatic logic [7:0] eff_hi(input logic [7:0] page);
    return (page < 8'hE0) ? page : (page & 8'hDF);
  endfunction

  assign reg_wr = mcyc_en && cpu_wr && (a == DMA_REG_ADDR);

  // State register; everything only moves on enabled machine-cycle edges.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q        <= IDLE;
      idx_q          <= 8'h00;
      src_hi_q       <= 8'h00;
      active_hi_q    <= 8'h00;
      restart_pend_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      src_hi_q       <= src_hi_d;
      active_hi_q    <= active_hi_d;
      restart_pend_q <= restart_pend_d;
    end
  end

  // Next-state logic: a restart during RUN keeps the old page (active_hi)
  // for one overlap cycle, then reloads page and index without dropping run.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    src_hi_d       = src_hi_q;
    active_hi_d    = active_hi_q;
    restart_pend_d = restart_pend_q;

    if (mcyc_en) begin
      if (reg_wr) begin
        src_hi_d = d;
      end

      unique case (state_q)
        IDLE: begin
          idx_d = 8'h00;
          if (reg_wr) begin
            state_d = SETUP;
          end
        end

        SETUP: begin
          idx_d = 8'h00;
          if (!reg_wr) begin
            state_d     = RUN;
            active_hi_d = eff_hi(src_hi_q);
          end
        end

        RUN: begin
          if (restart_pend_q) begin
            idx_d          = 8'h00;
            active_hi_d    = eff_hi(src_hi_d);
            restart_pend_d = 1'b0;
          end else begin
            if (reg_wr) begin
              restart_pend_d = 1'b1;
            end
            if (idx_q == LAST_IDX) begin
              if (reg_wr) begin
                idx_d = idx_q;
              end else begin
                state_d = IDLE;
                idx_d   = 8'h00;
              end
            end else begin
              idx_d = idx_q + 8'd1;
            end
          end
        end

        default: begin
          state_d        = IDLE;
          idx_d          = 8'h00;
          restart_pend_d = 1'b0;
        end
      endcase
    end
  end

  assign dma_run       = (state_q == RUN);
  assign dma_a         = dma_run ? {active_hi_q, idx_q} : 16'h0000;
  assign oam_addr_ndma = !dma_run;
  assign dma_oam_wr    = dma_run;
  assign vram_to_oam   = dma_run && (active_hi_q[7:5] == 3'b100);

  assign q    = src_hi_q;
  assign q_oe = cpu_rd && (a == DMA_REG_ADDR);

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed testbench for oam_dma_ctrl. One machine cycle per clock except
// where mcyc_en is deliberately dropped.
module tb_oam_dma_ctrl;

  logic        clk = 1'b0;
  logic        nreset;
  logic        mcyc_en;
  logic [15:0] a;
  logic [7:0]  d;
  logic        cpu_wr;
  logic        cpu_rd;
  logic [7:0]  q;
  logic        q_oe;
  logic        dma_run;
  logic [15:0] dma_a;
  logic        oam_addr_ndma;
  logic        vram_to_oam;
  logic        dma_oam_wr;

  int checks = 0;
  int errors = 0;
  int run_cycles = 0;

  localparam logic [19:0] IDLE_OUT = {1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};

  oam_dma_ctrl dut (
    .clk(clk), .nreset(nreset), .mcyc_en(mcyc_en), .a(a), .d(d),
    .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .q(q), .q_oe(q_oe),
    .dma_run(dma_run), .dma_a(dma_a), .oam_addr_ndma(oam_addr_ndma),
    .vram_to_oam(vram_to_oam), .dma_oam_wr(dma_oam_wr)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Counts machine cycles with a transfer in progress, sampled mid-cycle.
  always @(negedge clk) begin
    if (dma_run && mcyc_en) run_cycles++;
  end

  // Bound on total run time.
  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [19:0] run_out(input logic [7:0] hi, input logic [7:0] idx, input logic vram);
    return {1'b1, 1'b0, 1'b1, vram, hi, idx};
  endfunction

  function automatic logic [19:0] obs();
    return {dma_run, oam_addr_ndma, dma_oam_wr, vram_to_oam, dma_a};
  endfunction

  task automatic check_output(input string tag, input logic [19:0] observed, input logic [19:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic wr, input logic [15:0] addr, input logic [7:0] data);
    cpu_wr = wr;
    a      = addr;
    d      = data;
    @(posedge clk);
    #1;
    cpu_wr = 1'b0;
    a      = 16'h0000;
    d      = 8'h00;
  endtask

  task automatic step();
    apply_stimulus(1'b0, 16'h0000, 8'h00);
  endtask

  task automatic check_read(input string tag, input logic [15:0] addr, input logic oe_e, input logic [7:0] q_e);
    cpu_rd = 1'b1;
    a      = addr;
    #1;
    check_output(tag, {11'h000, q_oe, q}, {11'h000, oe_e, q_e});
    cpu_rd = 1'b0;
    a      = 16'h0000;
  endtask

  // Checks the current cycle at idx=first, then steps through to idx=last.
  task automatic run_span(input string tag, input logic [7:0] hi, input int first, input int last, input logic vram);
    for (int i = first; i <= last; i++) begin
      check_output(tag, obs(), run_out(hi, i[7:0], vram));
      if (i < last) step();
    end
  endtask

  initial begin
    nreset  = 1'b0;
    mcyc_en = 1'b1;
    cpu_wr  = 1'b0;
    cpu_rd  = 1'b0;
    a       = 16'h0000;
    d       = 8'h00;
    #2;
    check_output("reset_outputs", obs(), IDLE_OUT);
    check_read("reset_q", 16'hFF46, 1'b1, 8'h00);
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk);
    #1;

    // Wrong address and gated strobe must not start anything.
    apply_stimulus(1'b1, 16'hFF47, 8'h55);
    check_output("wrong_addr_idle", obs(), IDLE_OUT);
    check_read("wrong_addr_q", 16'hFF46, 1'b1, 8'h00);
    check_read("q_oe_other_addr", 16'hFF47, 1'b0, 8'h00);
    mcyc_en = 1'b0;
    apply_stimulus(1'b1, 16'hFF46, 8'h66);
    mcyc_en = 1'b1;
    check_output("gated_wr_idle", obs(), IDLE_OUT);
    check_read("gated_wr_q", 16'hFF46, 1'b1, 8'h00);

    // Plain WRAM page.
    run_cycles = 0;
    apply_stimulus(1'b1, 16'hFF46, 8'hC1);
    check_output("c1_setup", obs(), IDLE_OUT);
    step();
    run_span("c1_run", 8'hC1, 0, 159, 1'b0);
    step();
    check_output("c1_end", obs(), IDLE_OUT);
    check_output("c1_cycles", 20'(run_cycles), 20'd160);

    // VRAM page.
    apply_stimulus(1'b1, 16'hFF46, 8'h80);
    step();
    run_span("v80_run", 8'h80, 0, 159, 1'b1);
    step();
    check_output("v80_end", obs(), IDLE_OUT);

    // Echo page folds down; readback keeps the raw value.
    apply_stimulus(1'b1, 16'hFF46, 8'hFE);
    check_read("fe_q", 16'hFF46, 1'b1, 8'hFE);
    step();
    run_span("fe_run", 8'hDE, 0, 159, 1'b0);
    step();
    check_output("fe_end", obs(), IDLE_OUT);

    // Restart mid-run.
    run_cycles = 0;
    apply_stimulus(1'b1, 16'hFF46, 8'hC0);
    step();
    run_span("c0_run", 8'hC0, 0, 8'h40, 1'b0);
    apply_stimulus(1'b1, 16'hFF46, 8'hD0);
    check_output("restart_overlap", obs(), run_out(8'hC0, 8'h41, 1'b0));
    step();
    run_span("d0_run", 8'hD0, 0, 159, 1'b0);
    step();
    check_output("d0_end", obs(), IDLE_OUT);
    check_output("restart_cycles", 20'(run_cycles), 20'd226);

    // Restart landing on the last index.
    apply_stimulus(1'b1, 16'hFF46, 8'hC5);
    step();
    run_span("c5_run", 8'hC5, 0, 159, 1'b0);
    apply_stimulus(1'b1, 16'hFF46, 8'hC6);
    check_output("last_idx_overlap", obs(), run_out(8'hC5, 8'h9F, 1'b0));
    step();
    run_span("c6_run", 8'hC6, 0, 159, 1'b0);
    step();
    check_output("c6_end", obs(), IDLE_OUT);

    // Machine-cycle strobe held low mid-run.
    apply_stimulus(1'b1, 16'hFF46, 8'hC4);
    step();
    run_span("c4_pre", 8'hC4, 0, 8'h10, 1'b0);
    mcyc_en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check_output("c4_frozen", obs(), run_out(8'hC4, 8'h10, 1'b0));
    end
    mcyc_en = 1'b1;
    step();
    run_span("c4_post", 8'hC4, 8'h11, 159, 1'b0);
    step();
    check_output("c4_end", obs(), IDLE_OUT);

    // Asynchronous reset mid-run, then a fresh transfer.
    apply_stimulus(1'b1, 16'hFF46, 8'hC2);
    step();
    run_span("c2_run", 8'hC2, 0, 8'h50, 1'b0);
    #2;
    nreset = 1'b0;
    #1;
    check_output("async_reset", obs(), IDLE_OUT);
    check_read("async_reset_q", 16'hFF46, 1'b1, 8'h00);
    nreset = 1'b1;
    run_cycles = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      check_output("post_reset_quiet", obs(), IDLE_OUT);
    end
    check_output("post_reset_cycles", 20'(run_cycles), 20'd0);
    apply_stimulus(1'b1, 16'hFF46, 8'hC3);
    step();
    run_span("c3_run", 8'hC3, 0, 159, 1'b0);
    step();
    check_output("c3_end", obs(), IDLE_OUT);
    check_output("c3_cycles", 20'(run_cycles), 20'd160);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
